// File: rtl/seg_scan_driver_if.sv
//------------------------------------------------------------------------------
// Module  : seg_scan_driver_if
// Brief   : Register-side and pin-side signal bundle of the 7-segment scanner.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seg_scan_driver_if #(
    parameter int DIGITS = 8,
    parameter int SEL_W  = 3
);
    logic                  en;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     blank;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;
    logic                  seg_dp;
    logic [SEL_W-1:0]      sel;
    logic                  frame_done;

    modport master (
        output en, data, dp, blank,
        input  an, seg, seg_dp, sel, frame_done
    );

    modport slave (
        input  en, data, dp, blank,
        output an, seg, seg_dp, sel, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/seg_scan_driver.sv
//------------------------------------------------------------------------------
// Module  : seg_scan_driver
// Brief   : Multiplexed 7-segment scanner with guard interval, blanking,
//           leading-zero suppression and per-frame input snapshot.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan_driver #(
    parameter int DIGITS      = 8,
    parameter int SEL_W       = 3,
    parameter int DIV         = 50000,
    parameter int GUARD       = 4,
    parameter int AN_LOW      = 1,
    parameter int SEG_LOW     = 1,
    parameter int LZ_SUPPRESS = 1
) (
    input  wire                 clk,
    input  wire                 reset_n,
    seg_scan_driver_if.slave    io_bus
);

    localparam int c_CNT_MAX = (DIV > GUARD) ? DIV : GUARD;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_DIV_LAST   = c_CNT_W'(DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GUARD_LAST = c_CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [SEL_W-1:0]   c_SEL_LAST   = SEL_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0]  c_AN_INV     = (AN_LOW != 0)  ? '1 : '0;
    localparam logic [6:0]         c_SEG_INV    = (SEG_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic               c_DP_INV     = (SEG_LOW != 0);
    localparam logic [DIGITS-1:0]  c_AN_ONE     = {{(DIGITS-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHOW  = 2'd1;
    localparam logic [1:0] c_S_GUARD = 2'd2;

    // Segment order {g,f,e,d,c,b,a}, logical 1 = lit
    function automatic logic [6:0] f_dec7(input logic [3:0] nib);
        logic [6:0] v;
        case (nib)
            4'h0: v = 7'b0111111;  4'h1: v = 7'b0000110;
            4'h2: v = 7'b1011011;  4'h3: v = 7'b1001111;
            4'h4: v = 7'b1100110;  4'h5: v = 7'b1101101;
            4'h6: v = 7'b1111101;  4'h7: v = 7'b0000111;
            4'h8: v = 7'b1111111;  4'h9: v = 7'b1101111;
            4'hA: v = 7'b1110111;  4'hB: v = 7'b1111100;
            4'hC: v = 7'b0111001;  4'hD: v = 7'b1011110;
            4'hE: v = 7'b1111001;  default: v = 7'b1110001;
        endcase
        return v;
    endfunction

    logic [1:0]             r_state;
    logic [SEL_W-1:0]       r_sel;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [4*DIGITS-1:0]    r_snap_data;
    logic [DIGITS-1:0]      r_snap_dp;
    logic [DIGITS-1:0]      r_snap_blank;
    logic [DIGITS-1:0]      r_an;
    logic [6:0]             r_seg;
    logic                   r_seg_dp;
    logic                   r_frame_done;

    logic [1:0]             w_state_nxt;
    logic [SEL_W-1:0]       w_sel_nxt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic                   w_load;
    logic                   w_fd_nxt;
    logic [4*DIGITS-1:0]    w_snap_data;
    logic [DIGITS-1:0]      w_snap_dp;
    logic [DIGITS-1:0]      w_snap_blank;
    logic [DIGITS-1:0]      w_sup;
    logic                   w_run;
    logic                   w_lit;
    logic [3:0]             w_nib;
    logic [DIGITS-1:0]      w_an_nxt;
    logic [6:0]             w_seg_nxt;
    logic                   w_dp_nxt;

    // State register, snapshot and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_S_IDLE;
            r_sel        <= '0;
            r_cnt        <= '0;
            r_snap_data  <= '0;
            r_snap_dp    <= '0;
            r_snap_blank <= '0;
            r_an         <= c_AN_INV;
            r_seg        <= c_SEG_INV;
            r_seg_dp     <= c_DP_INV;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_cnt        <= w_cnt_nxt;
            r_snap_data  <= w_snap_data;
            r_snap_dp    <= w_snap_dp;
            r_snap_blank <= w_snap_blank;
            r_an         <= w_an_nxt ^ c_AN_INV;
            r_seg        <= w_seg_nxt ^ c_SEG_INV;
            r_seg_dp     <= w_dp_nxt ^ c_DP_INV;
            r_frame_done <= w_fd_nxt;
        end
    end

    // Next-state logic; the snapshot is loaded whenever SHOW is entered for digit 0
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_fd_nxt    = 1'b0;
        if (!io_bus.en) begin
            w_state_nxt = c_S_IDLE;
            w_sel_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    w_state_nxt = c_S_SHOW;
                    w_sel_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                end
                c_S_SHOW: begin
                    if (r_cnt == c_DIV_LAST) begin
                        w_cnt_nxt = '0;
                        w_sel_nxt = (r_sel == c_SEL_LAST) ? '0 : r_sel + 1'b1;
                        w_fd_nxt  = (r_sel == c_SEL_LAST);
                        if (GUARD == 0) begin
                            w_state_nxt = c_S_SHOW;
                            w_load      = (r_sel == c_SEL_LAST);
                        end else begin
                            w_state_nxt = c_S_GUARD;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                c_S_GUARD: begin
                    if (r_cnt == c_GUARD_LAST) begin
                        w_state_nxt = c_S_SHOW;
                        w_cnt_nxt   = '0;
                        w_load      = (r_sel == '0);
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_S_IDLE;
                    w_sel_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output logic, evaluated on next-cycle values so the pins line up with the state
    always_comb begin
        w_snap_data  = w_load ? io_bus.data  : r_snap_data;
        w_snap_dp    = w_load ? io_bus.dp    : r_snap_dp;
        w_snap_blank = w_load ? io_bus.blank : r_snap_blank;

        w_sup = '0;
        w_run = 1'b1;
        if (LZ_SUPPRESS != 0) begin
            for (int i = DIGITS - 1; i >= 1; i--) begin
                w_run    = w_run & (w_snap_data[4*i +: 4] == 4'h0) & ~w_snap_dp[i];
                w_sup[i] = w_run;
            end
        end

        w_nib     = w_snap_data[{w_sel_nxt, 2'b00} +: 4];
        w_lit     = (w_state_nxt == c_S_SHOW) &&
                    !(w_snap_blank[w_sel_nxt] || w_sup[w_sel_nxt]);
        w_an_nxt  = w_lit ? (c_AN_ONE << w_sel_nxt) : '0;
        w_seg_nxt = w_lit ? f_dec7(w_nib) : 7'h00;
        w_dp_nxt  = w_lit & w_snap_dp[w_sel_nxt];
    end

    assign io_bus.an         = r_an;
    assign io_bus.seg        = r_seg;
    assign io_bus.seg_dp     = r_seg_dp;
    assign io_bus.sel        = r_sel;
    assign io_bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
//------------------------------------------------------------------------------
// Module  : tb_seg_scan_driver
// Brief   : Directed bench for seg_scan_driver (8-digit active-low and
//           6-digit active-high instances).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_driver;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seg_scan_driver_if #(.DIGITS(8), .SEL_W(3)) bus8 ();
    seg_scan_driver_if #(.DIGITS(6), .SEL_W(3)) bus6 ();

    seg_scan_driver #(
        .DIGITS(8), .SEL_W(3), .DIV(4), .GUARD(2),
        .AN_LOW(1), .SEG_LOW(1), .LZ_SUPPRESS(1)
    ) u_dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (bus8)
    );

    seg_scan_driver #(
        .DIGITS(6), .SEL_W(3), .DIV(3), .GUARD(1),
        .AN_LOW(0), .SEG_LOW(0), .LZ_SUPPRESS(0)
    ) u_dut6 (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (bus6)
    );

    // Reference hex-to-segment table, {g,f,e,d,c,b,a}, 1 = lit
    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 48-cycle frame of the 8-digit instance; optional input change at cycle chg
    task automatic frame8(input logic [31:0] d, input logic [7:0] dpv, input logic [7:0] dark,
                          input int chg, input logic [31:0] nd, input logic [7:0] ndp);
        for (int i = 0; i < 48; i++) begin
            int k;
            logic [7:0] e_an;
            logic [6:0] e_seg;
            logic       e_dp;
            logic [2:0] e_sel;
            @(posedge clk); #1;
            k = i / 6;
            if ((i % 6) < 4 && !dark[k]) begin
                e_an  = 8'(1 << k);
                e_seg = ref_seg(d[4*k +: 4]);
                e_dp  = dpv[k];
            end else begin
                e_an  = 8'h00;
                e_seg = 7'h00;
                e_dp  = 1'b0;
            end
            e_sel = ((i % 6) < 4) ? 3'(k) : 3'((k + 1) % 8);
            chk($sformatf("f8 an i=%0d", i),  {24'h0, bus8.an},  {24'h0, ~e_an});
            chk($sformatf("f8 seg i=%0d", i), {25'h0, bus8.seg}, {25'h0, ~e_seg});
            chk($sformatf("f8 dp i=%0d", i),  {31'h0, bus8.seg_dp}, {31'h0, ~e_dp});
            chk($sformatf("f8 sel i=%0d", i), {29'h0, bus8.sel}, {29'h0, e_sel});
            chk($sformatf("f8 fd i=%0d", i),  {31'h0, bus8.frame_done}, {31'h0, (i == 46)});
            if (i == chg) begin
                bus8.data = nd;
                bus8.dp   = ndp;
            end
        end
    endtask

    // One 24-cycle frame of the 6-digit active-high instance
    task automatic frame6(input logic [23:0] d, input logic [5:0] dpv, input logic [5:0] dark);
        for (int i = 0; i < 24; i++) begin
            int k;
            logic [5:0] e_an;
            logic [6:0] e_seg;
            logic       e_dp;
            logic [2:0] e_sel;
            @(posedge clk); #1;
            k = i / 4;
            if ((i % 4) < 3 && !dark[k]) begin
                e_an  = 6'(1 << k);
                e_seg = ref_seg(d[4*k +: 4]);
                e_dp  = dpv[k];
            end else begin
                e_an  = 6'h00;
                e_seg = 7'h00;
                e_dp  = 1'b0;
            end
            e_sel = ((i % 4) < 3) ? 3'(k) : 3'((k + 1) % 6);
            chk($sformatf("f6 an i=%0d", i),  {26'h0, bus6.an},  {26'h0, e_an});
            chk($sformatf("f6 seg i=%0d", i), {25'h0, bus6.seg}, {25'h0, e_seg});
            chk($sformatf("f6 dp i=%0d", i),  {31'h0, bus6.seg_dp}, {31'h0, e_dp});
            chk($sformatf("f6 sel i=%0d", i), {29'h0, bus6.sel}, {29'h0, e_sel});
            chk($sformatf("f6 fd i=%0d", i),  {31'h0, bus6.frame_done}, {31'h0, (i == 23)});
        end
    endtask

    task automatic idle8(input string tag);
        chk({tag, " an"},  {24'h0, bus8.an},  32'hFF);
        chk({tag, " seg"}, {25'h0, bus8.seg}, 32'h7F);
        chk({tag, " dp"},  {31'h0, bus8.seg_dp}, 32'h1);
        chk({tag, " sel"}, {29'h0, bus8.sel}, 32'h0);
        chk({tag, " fd"},  {31'h0, bus8.frame_done}, 32'h0);
    endtask

    initial begin
        bus8.en = 1'b0; bus8.data = 32'h0; bus8.dp = 8'h0; bus8.blank = 8'h0;
        bus6.en = 1'b0; bus6.data = 24'h0; bus6.dp = 6'h0; bus6.blank = 6'h0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        idle8("rst8");
        chk("rst6 an",  {26'h0, bus6.an},  32'h0);
        chk("rst6 seg", {25'h0, bus6.seg}, 32'h0);
        chk("rst6 dp",  {31'h0, bus6.seg_dp}, 32'h0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        idle8("idle8");

        // Plain scan, two frames with a mid-frame data change at digit 3
        bus8.data = 32'h76543210;
        bus8.en   = 1'b1;
        frame8(32'h76543210, 8'h00, 8'h00, -1, 32'h0, 8'h0);
        frame8(32'h76543210, 8'h00, 8'h00, 19, 32'hFEDCBA98, 8'h0F);
        frame8(32'hFEDCBA98, 8'h0F, 8'h00, -1, 32'h0, 8'h0);

        // Disable mid-SHOW on digit 1
        repeat (7) @(posedge clk);
        #1;
        chk("pre-dis an",  {24'h0, bus8.an},  {24'h0, ~8'h02});
        chk("pre-dis seg", {25'h0, bus8.seg}, {25'h0, ~7'h6F});
        bus8.en = 1'b0;
        @(posedge clk); #1;
        idle8("dis1");
        @(posedge clk); #1;
        idle8("dis2");

        // Leading-zero suppression, then a dp on digit 4 stops suppression there
        bus8.data = 32'h000000A5;
        bus8.dp   = 8'h00;
        bus8.en   = 1'b1;
        frame8(32'h000000A5, 8'h00, 8'hFC, 10, 32'h000000A5, 8'h10);
        frame8(32'h000000A5, 8'h10, 8'hE0, -1, 32'h0, 8'h0);

        // Asynchronous reset in the first guard cycle after digit 0
        repeat (5) @(posedge clk);
        #1;
        chk("pre-rst guard an",  {24'h0, bus8.an},  32'hFF);
        chk("pre-rst guard sel", {29'h0, bus8.sel}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        idle8("async rst");
        @(negedge clk) reset_n = 1'b1;
        frame8(32'h000000A5, 8'h10, 8'hE0, -1, 32'h0, 8'h0);

        // Six-digit instance: wrap 5->0, active-high pins, blanking, no suppression
        bus6.data  = 24'h0C0123;
        bus6.dp    = 6'b100001;
        bus6.blank = 6'b000100;
        bus6.en    = 1'b1;
        frame6(24'h0C0123, 6'b100001, 6'b000100);
        frame6(24'h0C0123, 6'b100001, 6'b000100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
